hilo_div_unit: RTL and testbench

//   Holds the architectural HI/LO pair for the datapath and is the other end of the ALU's HI/LO interface.

---
 rtl/hilo_pkg.sv | 19 +
 rtl/hilo_div_step.sv | 28 ++
 rtl/hilo_div_unit.sv | 168 ++++++++++++++++
 tb/tb_hilo_div_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO register pair and its iterative divider.
// The optional bypass feature is selected with HILO_FORWARD_EN in hilo_div_unit.
package hilo_pkg;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    // MoveOp encodings; 2'b11 is reserved and behaves as no-op.
    localparam logic [1:0] MOVE_NONE = 2'b00;
    localparam logic [1:0] MOVE_HI   = 2'b01;
    localparam logic [1:0] MOVE_LO   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DIV  = 2'b01,
        ST_FIX  = 2'b10
    } div_state_e;

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module hilo_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, div_i};
        // A restore only happens when rem_sh < divisor, so the dropped top bit is zero.
        if (diff[WIDTH]) begin
            rem_o = rem_sh[WIDTH-1:0];
        end else begin
            rem_o = diff[WIDTH-1:0];
        end
        quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
    end

endmodule

// File: rtl/hilo_div_unit.sv
// Architectural HI/LO pair with mult capture, mthi/mtlo and a 33-cycle div/divu.
// Define HILO_FORWARD_EN to bypass same-cycle writes onto the HI/LO outputs.
module hilo_div_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             WriteEn,
    input  logic [WIDTH-1:0] HIIn,
    input  logic [WIDTH-1:0] LOIn,
    input  logic [1:0]       MoveOp,
    input  logic [WIDTH-1:0] MoveData,
    input  logic             DivStart,
    input  logic             DivSigned,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             DivDone,
    output logic             DivByZero,
    output logic [1:0]       DbgState
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_rem, step_quo;

    hilo_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        a_neg = DivSigned & Dividend[WIDTH-1];
        b_neg = DivSigned & Divisor[WIDTH-1];
        a_mag = a_neg ? (~Dividend + 1'b1) : Dividend;
        b_mag = b_neg ? (~Divisor + 1'b1) : Divisor;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (DivStart) begin
                    state_d   = ST_DIV;
                    cnt_d     = CNT_W'(DIV_ITERS - 1);
                    rem_d     = '0;
                    quo_d     = a_mag;
                    dvs_d     = b_mag;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    zero_d    = (Divisor == '0);
                end
            end
            ST_DIV: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                dbz_d   = zero_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Division result beats WriteEn, WriteEn beats MoveOp; nothing else writes while busy.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == ST_FIX) begin
            hi_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
            if (zero_q) begin
                lo_d = '1;
            end else begin
                lo_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
            end
        end else if (state_q == ST_IDLE) begin
            if (WriteEn) begin
                hi_d = HIIn;
                lo_d = LOIn;
            end else if (MoveOp == MOVE_HI) begin
                hi_d = MoveData;
            end else if (MoveOp == MOVE_LO) begin
                lo_d = MoveData;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

`ifdef HILO_FORWARD_EN
    assign HI = hi_d;
    assign LO = lo_d;
`else
    assign HI = hi_q;
    assign LO = lo_q;
`endif

    assign Busy      = (state_q != ST_IDLE);
    assign DivDone   = done_q;
    assign DivByZero = dbz_q;
    assign DbgState  = state_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Bench for hilo_div_unit: directed HI/LO writes, a division vector table,
// hand-written multi-cycle corner sequences and randomized divisions.
module tb_hilo_div_unit;
    localparam int W = 32;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         write_en = 1'b0;
    logic [W-1:0] hi_in = '0;
    logic [W-1:0] lo_in = '0;
    logic [1:0]   move_op = 2'b00;
    logic [W-1:0] move_data = '0;
    logic         div_start = 1'b0;
    logic         div_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] hi_out, lo_out;
    logic         busy, div_done, div_by_zero;
    logic [1:0]   dbg_state;

    int n_pass = 0;
    int n_total = 0;
    int busy_cnt = 0;
    logic [2*W:0] exp_q[$];

    hilo_div_unit #(.WIDTH(W)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .WriteEn   (write_en),
        .HIIn      (hi_in),
        .LOIn      (lo_in),
        .MoveOp    (move_op),
        .MoveData  (move_data),
        .DivStart  (div_start),
        .DivSigned (div_signed),
        .Dividend  (dividend),
        .Divisor   (divisor),
        .HI        (hi_out),
        .LO        (lo_out),
        .Busy      (busy),
        .DivDone   (div_done),
        .DivByZero (div_by_zero),
        .DbgState  (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        if (busy) busy_cnt++;
    endtask

    // Reference model: plain integer division with the architectural corner rules.
    function automatic logic [2*W:0] ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb;
        logic [W-1:0] q, r;
        sa = a;
        sb = b;
        if (b == 0) begin
            return {1'b1, a, {W{1'b1}}};
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {1'b0, r, q};
    endfunction

    // Drivers
    task automatic write_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
        @(negedge clk);
        write_en = 1'b1; hi_in = h; lo_in = l;
        @(posedge clk);
        #1 write_en = 1'b0;
    endtask

    task automatic start_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W:0] exp);
        exp_q.push_back(exp);
        @(negedge clk);
        div_start = 1'b1; div_signed = sgn; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        div_signed = $urandom_range(0, 1);
        dividend = $urandom;
        divisor = $urandom;
        busy_cnt = 0;
    endtask

    task automatic wait_div(input string name);
        logic [2*W:0] exp;
        bit seen;
        int cyc;
        seen = 0;
        cyc = 0;
        while (!seen && cyc < 100) begin
            tick();
            cyc++;
            if (div_done) seen = 1;
        end
        exp = exp_q.pop_front();
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({name, "_hi"}, 64'(hi_out), 64'(exp[2*W-1:W]));
        check({name, "_lo"}, 64'(lo_out), 64'(exp[W-1:0]));
        check({name, "_dbz"}, 64'(div_by_zero), 64'(exp[2*W]));
        tick();
        check({name, "_done_pulse"}, {62'd0, div_done, div_by_zero}, 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        logic [W-1:0] a, b, prev_lo;
        logic sgn;
        int done_cnt;

        vecs[0] = '{1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};
        vecs[3] = '{1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0};

        do_reset();
        @(negedge clk);
        check("reset_hi", 64'(hi_out), 64'd0);
        check("reset_lo", 64'(lo_out), 64'd0);
        check("reset_flags", {61'd0, busy, div_done, div_by_zero}, 64'd0);

        write_hilo(32'h1, 32'h2);
        @(negedge clk);
        check("wren_hi", 64'(hi_out), 64'd1);
        check("wren_lo", 64'(lo_out), 64'd2);
        check("wren_busy", 64'(busy), 64'd0);

        // WriteEn beats mthi in the same cycle; reserved MoveOp is a no-op.
        @(negedge clk);
        write_en = 1'b1; hi_in = 32'h11; lo_in = 32'h22; move_op = 2'b01; move_data = 32'h99;
        @(posedge clk);
        #1 write_en = 1'b0;
        move_op = 2'b11; move_data = 32'h77;
        @(posedge clk);
        #1 move_op = 2'b00;
        @(negedge clk);
        check("prio_hi", 64'(hi_out), 64'h11);
        check("prio_lo", 64'(lo_out), 64'h22);

        foreach (vecs[i]) begin
            start_div(vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].dbz, vecs[i].hi, vecs[i].lo});
            wait_div($sformatf("vec%0d", i));
        end

        // Writes during a division are ignored.
        write_hilo(32'h5555, 32'h6666);
        start_div(1'b0, 32'd1000, 32'd33, ref_div(1'b0, 32'd1000, 32'd33));
        repeat (5) tick();
        write_en = 1'b1; hi_in = 32'hDEAD; lo_in = 32'hBEEF; move_op = 2'b01; move_data = 32'hF00D;
        tick();
        write_en = 1'b0; move_op = 2'b10;
        tick();
        move_op = 2'b00;
        check("middiv_hi", 64'(hi_out), 64'h5555);
        check("middiv_lo", 64'(lo_out), 64'h6666);
        wait_div("middiv");

        // DivStart together with WriteEn: the write lands now, the result later.
        @(negedge clk);
        write_en = 1'b1; hi_in = 32'hA1; lo_in = 32'hB2;
        start_div(1'b1, 32'hFFFF_FF00, 32'd16, ref_div(1'b1, 32'hFFFF_FF00, 32'd16));
        write_en = 1'b0;
        tick();
        check("startwr_hi", 64'(hi_out), 64'hA1);
        check("startwr_lo", 64'(lo_out), 64'hB2);
        wait_div("startwr");

        // Reset ten cycles into a division aborts it.
        start_div(1'b0, 32'd12345, 32'd3, ref_div(1'b0, 32'd12345, 32'd3));
        repeat (10) tick();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_hilo", {hi_out, lo_out}, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);

        // mtlo visibility timing.
        prev_lo = lo_out;
        @(negedge clk);
        move_op = 2'b10; move_data = 32'hABCD;
        #1;
`ifdef HILO_FORWARD_EN
        check("mtlo_same_cycle", 64'(lo_out), 64'hABCD);
`else
        check("mtlo_same_cycle", 64'(lo_out), 64'(prev_lo));
`endif
        @(posedge clk);
        #1 move_op = 2'b00;
        @(negedge clk);
        check("mtlo_next_cycle", 64'(lo_out), 64'hABCD);
        check("mtlo_hi_kept", 64'(hi_out), 64'd0);

        // Randomized divisions against the model.
        for (int i = 0; i < 20; i++) begin
            sgn = $urandom_range(0, 1);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            start_div(sgn, a, b, ref_div(sgn, a, b));
            wait_div($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
